// File: rtl/pc_seq_ctrl.sv
// Sequencing controller for the dual-function PC: fetch handshake, execute wait,
// next-PC arbitration (trap / branch / step) and a single-cycle PC update command.
module pc_seq_ctrl #(
  parameter logic [31:0] STEP     = 32'd4,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        imem_ack,
  input  logic        exec_done,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        branch_abs,
  input  logic [31:0] branch_target,
  input  logic        trap,
  input  logic        halt_req,
  output logic        imem_req,
  output logic        pc_enable,
  output logic        pc_mode,
  output logic [31:0] pc_datain,
  output logic        instr_valid,
  output logic        fault,
  output logic        halted,
  output logic [31:0] retire_count
);

  localparam int unsigned WW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  logic [2:0]    state, state_d;
  logic [WW-1:0] wait_cnt, wait_cnt_d;
  logic          halt_q;
  logic          mode_d;
  logic [31:0]   data_d;
  logic          retire_d;
  logic          fault_d;
  logic          timeout;

  // Next-state and update-command selection; trap outranks ack, timeout and exec_done.
  always_comb begin
    state_d    = state;
    wait_cnt_d = '0;
    mode_d     = 1'b0;
    data_d     = '0;
    retire_d   = 1'b0;
    fault_d    = 1'b0;
    timeout    = (wait_cnt == WW'(MAX_WAIT - 1));
    case (state)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (trap) begin
          state_d = S_UPDATE;
          mode_d  = 1'b1;
          data_d  = TRAP_VEC;
        end else if (imem_ack) begin
          state_d = S_EXEC;
        end else if (timeout) begin
          state_d = S_UPDATE;
          mode_d  = 1'b1;
          data_d  = TRAP_VEC;
          fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + WW'(1);
        end
      end
      S_EXEC: begin
        if (trap) begin
          state_d = S_UPDATE;
          mode_d  = 1'b1;
          data_d  = TRAP_VEC;
        end else if (exec_done && !stall) begin
          state_d  = S_UPDATE;
          retire_d = 1'b1;
          if (branch_taken) begin
            mode_d = branch_abs;
            data_d = branch_target;
          end else begin
            mode_d = 1'b0;
            data_d = STEP;
          end
        end
      end
      S_UPDATE: begin
        state_d = halt_q ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  // Outputs are registered from the next state so no input reaches a port combinationally.
  always_ff @(posedge CLK) begin
    if (reset) begin
      imem_req     <= 1'b0;
      pc_enable    <= 1'b0;
      pc_mode      <= 1'b0;
      pc_datain    <= '0;
      instr_valid  <= 1'b0;
      fault        <= 1'b0;
      halted       <= 1'b0;
      retire_count <= '0;
      halt_q       <= 1'b0;
    end else begin
      imem_req    <= (state_d == S_FETCH);
      pc_enable   <= (state_d == S_UPDATE);
      pc_mode     <= mode_d;
      pc_datain   <= data_d;
      instr_valid <= (state == S_FETCH) && (state_d == S_EXEC);
      halted      <= (state_d == S_HALT);
      if (fault_d) fault <= 1'b1;
      if (retire_d) retire_count <= retire_count + 32'd1;
      if (halt_req && (state != S_IDLE) && (state != S_HALT)) halt_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: step, branches, trap priority, stall, timeout, halt, reset.
module tb_pc_seq_ctrl;

  logic        CLK;
  logic        reset;
  logic        start;
  logic        imem_ack;
  logic        exec_done;
  logic        stall;
  logic        branch_taken;
  logic        branch_abs;
  logic [31:0] branch_target;
  logic        trap;
  logic        halt_req;
  logic        imem_req;
  logic        pc_enable;
  logic        pc_mode;
  logic [31:0] pc_datain;
  logic        instr_valid;
  logic        fault;
  logic        halted;
  logic [31:0] retire_count;

  int checks = 0;
  int errors = 0;

  pc_seq_ctrl dut (
    .CLK          (CLK),
    .reset        (reset),
    .start        (start),
    .imem_ack     (imem_ack),
    .exec_done    (exec_done),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_abs   (branch_abs),
    .branch_target(branch_target),
    .trap         (trap),
    .halt_req     (halt_req),
    .imem_req     (imem_req),
    .pc_enable    (pc_enable),
    .pc_mode      (pc_mode),
    .pc_datain    (pc_datain),
    .instr_valid  (instr_valid),
    .fault        (fault),
    .halted       (halted),
    .retire_count (retire_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_upd(input string tag, input logic m, input logic [31:0] d, input logic [31:0] rc);
    check({tag, "_en"}, {31'd0, pc_enable}, 32'd1);
    check({tag, "_mode"}, {31'd0, pc_mode}, {31'd0, m});
    check({tag, "_data"}, pc_datain, d);
    check({tag, "_retire"}, retire_count, rc);
  endtask

  // From FETCH: acknowledge once and land in EXEC.
  task automatic fetch(input string tag);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check({tag, "_ivalid"}, {31'd0, instr_valid}, 32'd1);
  endtask

  // From EXEC: finish the instruction and land in UPDATE.
  task automatic exec(input logic tk, input logic ab, input logic [31:0] tgt);
    exec_done     = 1'b1;
    branch_taken  = tk;
    branch_abs    = ab;
    branch_target = tgt;
    tick();
    exec_done     = 1'b0;
    branch_taken  = 1'b0;
    branch_abs    = 1'b0;
    branch_target = '0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_abs = 1'b0; branch_target = '0; trap = 1'b0; halt_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_en", {31'd0, pc_enable}, 32'd0);
    check("rst_retire", retire_count, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);

    // Sequential step with ack on the second FETCH cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fetch1_req", {31'd0, imem_req}, 32'd1);
    tick();
    check("fetch2_req", {31'd0, imem_req}, 32'd1);
    fetch("seq");
    check("exec_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("ivalid_pulse", {31'd0, instr_valid}, 32'd0);
    check("exec_no_en", {31'd0, pc_enable}, 32'd0);
    exec(1'b0, 1'b0, 32'd0);
    check_upd("seq", 1'b0, 32'd4, 32'd1);
    tick();
    check("seq_back_en", {31'd0, pc_enable}, 32'd0);
    check("seq_back_data", pc_datain, 32'd0);
    check("seq_back_req", {31'd0, imem_req}, 32'd1);

    // Relative then absolute taken branches
    fetch("rel");
    exec(1'b1, 1'b0, 32'hFFFF_FFF8);
    check_upd("rel", 1'b0, 32'hFFFF_FFF8, 32'd2);
    tick();
    fetch("abs");
    exec(1'b1, 1'b1, 32'h0000_2000);
    check_upd("abs", 1'b1, 32'h0000_2000, 32'd3);
    tick();

    // Trap and exec_done together: trap wins, no retire
    fetch("trp");
    trap = 1'b1;
    exec(1'b1, 1'b1, 32'h0000_3000);
    trap = 1'b0;
    check_upd("trp", 1'b1, 32'h0000_0100, 32'd3);
    tick();

    // Stall holds EXEC for three cycles despite exec_done
    fetch("stl");
    stall = 1'b1;
    exec_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_en", {31'd0, pc_enable}, 32'd0);
    end
    stall = 1'b0;
    tick();
    check_upd("stl", 1'b0, 32'd4, 32'd4);
    tick();
    exec_done = 1'b0;
    check("stl_single_en", {31'd0, pc_enable}, 32'd0);
    check("stl_retire", retire_count, 32'd4);

    // Ack on the 16th FETCH cycle: no timeout
    for (int i = 0; i < 15; i++) tick();
    check("late_req", {31'd0, imem_req}, 32'd1);
    check("late_no_en", {31'd0, pc_enable}, 32'd0);
    fetch("late");
    check("late_fault", {31'd0, fault}, 32'd0);
    exec(1'b0, 1'b0, 32'd0);
    check_upd("late", 1'b0, 32'd4, 32'd5);
    tick();

    // No ack for 16 cycles: timeout trap, sticky fault
    for (int i = 0; i < 15; i++) tick();
    check("to_pre_en", {31'd0, pc_enable}, 32'd0);
    check("to_pre_fault", {31'd0, fault}, 32'd0);
    tick();
    check_upd("to", 1'b1, 32'h0000_0100, 32'd5);
    check("to_fault", {31'd0, fault}, 32'd1);
    tick();
    check("to_sticky", {31'd0, fault}, 32'd1);
    check("to_back_req", {31'd0, imem_req}, 32'd1);

    // Halt request pulsed during FETCH: finish the instruction then halt
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    fetch("hlt");
    exec(1'b0, 1'b0, 32'd0);
    check_upd("hlt", 1'b0, 32'd4, 32'd6);
    tick();
    check("hlt_halted", {31'd0, halted}, 32'd1);
    check("hlt_req", {31'd0, imem_req}, 32'd0);
    check("hlt_en", {31'd0, pc_enable}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("hlt_start_ign", {31'd0, halted}, 32'd1);
    check("hlt_start_req", {31'd0, imem_req}, 32'd0);

    // Reset clears the halt; then reset in the middle of an UPDATE
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch("mid");
    exec(1'b1, 1'b1, 32'h0000_4000);
    check_upd("mid", 1'b1, 32'h0000_4000, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_en", {31'd0, pc_enable}, 32'd0);
    check("mid_rst_mode", {31'd0, pc_mode}, 32'd0);
    check("mid_rst_data", pc_datain, 32'd0);
    check("mid_rst_retire", retire_count, 32'd0);
    check("mid_rst_fault", {31'd0, fault}, 32'd0);
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("idle_stays", {31'd0, imem_req}, 32'd0);

    // Halt latch was cleared: an instruction returns to FETCH
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch("post");
    exec(1'b0, 1'b0, 32'd0);
    tick();
    check("post_halted", {31'd0, halted}, 32'd0);
    check("post_req", {31'd0, imem_req}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
